// File: rtl/qos_egress_arb_pkg.sv
// Shared widths, state encoding and weight helper for the QoS egress arbiter.
package qos_egress_arb_pkg;
  localparam int DATA_W  = 12;
  localparam int NUM_CLS = 4;
  localparam int CNT_W   = 8;
  localparam int CRED_W  = 4;
  localparam int CLS_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A zero weight still earns one grant per reload round.
  function automatic logic [CRED_W-1:0] eff_weight(input logic [CRED_W-1:0] w);
    return (w == '0) ? CRED_W'(1) : w;
  endfunction
endpackage

// File: rtl/qos_egress_arb_if.sv
// Egress arbiter bundle: FIFO side, weights, downstream and status signals.
interface qos_egress_arb_if;
  import qos_egress_arb_pkg::*;

  logic                             active;
  logic [NUM_CLS-1:0]               empty;
  logic [NUM_CLS-1:0][DATA_W-1:0]   fifo_data;
  logic [NUM_CLS-1:0][CRED_W-1:0]   weight;
  logic                             out_almost_full;
  logic [CLS_W-1:0]                 cnt_sel;
  logic [NUM_CLS-1:0]               pop;
  logic [DATA_W-1:0]                data_out;
  logic                             valid_out;
  logic [CLS_W-1:0]                 class_out;
  logic [CNT_W-1:0]                 cnt_out;
  logic                             idle_out;

  modport master (
    output active, empty, fifo_data, weight, out_almost_full, cnt_sel,
    input  pop, data_out, valid_out, class_out, cnt_out, idle_out
  );
  modport slave (
    input  active, empty, fifo_data, weight, out_almost_full, cnt_sel,
    output pop, data_out, valid_out, class_out, cnt_out, idle_out
  );
endinterface

// File: rtl/qos_wrr_grant.sv
// Weighted round-robin grant: per-class credits, sticky pointer, one-hot grant.
module qos_wrr_grant
  import qos_egress_arb_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_en,
  input  logic [NUM_CLS-1:0]             i_empty,
  input  logic [NUM_CLS-1:0]             i_block,
  input  logic [NUM_CLS-1:0][CRED_W-1:0] i_weight,
  output logic [NUM_CLS-1:0]             o_gnt
);
  logic [NUM_CLS-1:0][CRED_W-1:0] r_cred, w_cred_eff, w_cred_nxt;
  logic [CLS_W-1:0]               r_ptr, w_gnt_idx, w_c;
  logic [NUM_CLS-1:0]             w_elig;
  logic                           w_reload, w_gnt_any;

  // Reload when no non-empty class has credit left; blocking does not matter here.
  always_comb begin
    w_reload = |(~i_empty);
    for (int i = 0; i < NUM_CLS; i++)
      if (!i_empty[i] && r_cred[i] != '0) w_reload = 1'b0;
    for (int i = 0; i < NUM_CLS; i++) begin
      w_cred_eff[i] = w_reload ? eff_weight(i_weight[i]) : r_cred[i];
      w_elig[i]     = i_en && !i_empty[i] && !i_block[i] && (w_cred_eff[i] != '0);
    end
  end

  // Descending scan so the class closest to the pointer wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = r_ptr;
    w_c       = r_ptr;
    for (int k = NUM_CLS-1; k >= 0; k--) begin
      w_c = r_ptr + CLS_W'(k);
      if (w_elig[w_c]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_c;
      end
    end
  end

  always_comb begin
    w_cred_nxt            = w_cred_eff;
    w_cred_nxt[w_gnt_idx] = w_cred_eff[w_gnt_idx] - CRED_W'(1);
  end

  assign o_gnt = w_gnt_any ? (NUM_CLS'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cred <= '0;
      r_ptr  <= '0;
    end else if (w_gnt_any) begin
      r_cred <= w_cred_nxt;
      r_ptr  <= w_gnt_idx;
    end
  end
endmodule

// File: rtl/qos_egress_arb.sv
// QoS egress arbiter top: run/drain FSM, registered egress word, per-class counters.
module qos_egress_arb
  import qos_egress_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  qos_egress_arb_if.slave eg
);
  state_e                         r_state, w_state_nxt;
  logic                           w_en, w_any_ne, r_vld;
  logic [NUM_CLS-1:0]             w_pop, r_last_pop;
  logic [CLS_W-1:0]               r_cls, w_pop_idx;
  logic [DATA_W-1:0]              r_hold, w_data;
  logic [NUM_CLS-1:0][CNT_W-1:0]  r_cnt;

  assign w_any_ne = ~&eg.empty;
  assign w_en     = (r_state == ST_RUN) && eg.active && !eg.out_almost_full;

  // Last cycle's pop blocks that class: its empty flag lags one cycle.
  qos_wrr_grant u_grant (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_en),
    .i_empty  (eg.empty),
    .i_block  (r_last_pop),
    .i_weight (eg.weight),
    .o_gnt    (w_pop)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (eg.active && w_any_ne) w_state_nxt = ST_RUN;
      ST_RUN:   if (!eg.active)                w_state_nxt = r_vld ? ST_DRAIN : ST_IDLE;
                else if (!w_any_ne && !r_vld)  w_state_nxt = ST_IDLE;
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_pop_idx = '0;
    for (int i = 0; i < NUM_CLS; i++)
      if (w_pop[i]) w_pop_idx = CLS_W'(i);
  end

  // FIFO read data arrives the cycle after pop; the hold register keeps it visible afterwards.
  assign w_data = r_vld ? eg.fifo_data[r_cls] : r_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld      <= 1'b0;
      r_cls      <= '0;
      r_hold     <= '0;
      r_last_pop <= '0;
      r_cnt      <= '0;
    end else begin
      r_vld      <= |w_pop;
      r_last_pop <= w_pop;
      if (|w_pop) r_cls <= w_pop_idx;
      if (r_vld) begin
        r_hold       <= w_data;
        r_cnt[r_cls] <= r_cnt[r_cls] + CNT_W'(1);
      end
    end
  end

  assign eg.pop       = w_pop;
  assign eg.data_out  = w_data;
  assign eg.valid_out = r_vld;
  assign eg.class_out = r_cls;
  assign eg.cnt_out   = r_cnt[eg.cnt_sel];
  assign eg.idle_out  = (r_state == ST_IDLE);
endmodule

// File: tb/tb_qos_egress_arb.sv
// Randomised bench for qos_egress_arb against a queue-based WRR reference model.
module tb_qos_egress_arb;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;
  typedef logic [11:0] word_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  qos_egress_arb_if eg();
  qos_egress_arb dut (.clk(clk), .reset(reset), .eg(eg));

  always #5 clk = ~clk;

  // FIFO contents held as simple arrays with head/tail pointers
  word_t mem [4][1024];
  int    hd [4];
  int    tl [4];

  // reference model state
  int         m_st, m_ptr, m_last, m_cls, g_sel, e_nst;
  int         m_cred [4];
  int         g_eff [4];
  logic       m_vld;
  word_t      m_word, m_hold;
  logic [7:0] m_cnt [4];

  logic [3:0] e_pop;
  logic       e_vld, e_idle;
  logic [1:0] e_cls;
  word_t      e_data;
  logic [7:0] e_cnt;

  function automatic void refresh_empty();
    for (int c = 0; c < 4; c++) eg.empty[c] = (tl[c] == hd[c]);
  endfunction

  function automatic void push_word(input int c);
    if (tl[c] < 1024) begin
      mem[c][tl[c]] = word_t'($urandom);
      tl[c]++;
    end
  endfunction

  function automatic void model_reset();
    m_st = S_IDLE; m_ptr = 0; m_last = -1; m_cls = 0; g_sel = -1; e_nst = S_IDLE;
    m_vld = 1'b0; m_word = '0; m_hold = '0;
    for (int c = 0; c < 4; c++) begin m_cred[c] = 0; m_cnt[c] = 8'd0; end
  endfunction

  // Expected outputs for the current cycle plus the grant and next state.
  function automatic void model_eval();
    bit any_ne, reload;
    any_ne = 1'b0; reload = 1'b1; g_sel = -1;
    for (int c = 0; c < 4; c++)
      if (tl[c] > hd[c]) begin
        any_ne = 1'b1;
        if (m_cred[c] != 0) reload = 1'b0;
      end
    reload = reload && any_ne;
    for (int c = 0; c < 4; c++)
      g_eff[c] = reload ? ((eg.weight[c] == 4'd0) ? 1 : int'(eg.weight[c])) : m_cred[c];
    if (m_st == S_RUN && eg.active && !eg.out_almost_full)
      for (int k = 0; k < 4; k++) begin
        int cc;
        cc = (m_ptr + k) % 4;
        if (g_sel < 0 && tl[cc] > hd[cc] && g_eff[cc] > 0 && cc != m_last) g_sel = cc;
      end
    e_pop  = (g_sel >= 0) ? 4'(1 << g_sel) : 4'b0;
    e_vld  = m_vld;
    e_cls  = 2'(m_cls);
    e_data = m_vld ? m_word : m_hold;
    e_idle = (m_st == S_IDLE);
    e_cnt  = m_cnt[eg.cnt_sel];
    case (m_st)
      S_IDLE:  e_nst = (eg.active && any_ne) ? S_RUN : S_IDLE;
      S_RUN:   if (!eg.active)             e_nst = m_vld ? S_DRAIN : S_IDLE;
               else if (!any_ne && !m_vld) e_nst = S_IDLE;
               else                        e_nst = S_RUN;
      default: e_nst = S_IDLE;
    endcase
  endfunction

  task automatic model_commit();
    @(posedge clk); #1;
    if (m_vld) begin
      m_cnt[m_cls] = m_cnt[m_cls] + 8'd1;
      m_hold = m_word;
    end
    m_vld  = (g_sel >= 0);
    m_last = g_sel;
    if (g_sel >= 0) begin
      for (int c = 0; c < 4; c++) m_cred[c] = g_eff[c];
      m_cred[g_sel]--;
      m_ptr  = g_sel;
      m_cls  = g_sel;
      m_word = mem[g_sel][hd[g_sel]];
      hd[g_sel]++;
      eg.fifo_data[g_sel] = m_word;
    end
    m_st = e_nst;
    refresh_empty();
  endtask

  function automatic logic [27:0] pack_got();
    return {eg.pop, eg.valid_out, eg.class_out, eg.data_out, eg.idle_out, eg.cnt_out};
  endfunction

  function automatic logic [27:0] pack_want();
    return {e_pop, e_vld, e_cls, e_data, e_idle, e_cnt};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      hd[c] = 0; tl[c] = 0; eg.fifo_data[c] = '0; eg.weight[c] = 4'd1;
    end
    eg.active = 1'b0; eg.out_almost_full = 1'b0; eg.cnt_sel = 2'd0;
    refresh_empty();
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin hd[c] = 0; tl[c] = 0; eg.fifo_data[c] = '0; eg.weight[c] = 4'd1; end
    eg.active = 1'b1; eg.out_almost_full = 1'b0; eg.cnt_sel = 2'd0;
    refresh_empty();
    #3 reset = 1'b1;
    #1;
    total++;
    if ({eg.pop, eg.valid_out, eg.data_out, eg.class_out, eg.idle_out} !== {4'b0, 1'b0, 12'h0, 2'd0, 1'b1})
      begin bad++; $display("FAIL reset_outputs got=%h want=%h", {eg.pop, eg.valid_out, eg.data_out, eg.class_out, eg.idle_out}, {4'b0, 1'b0, 12'h0, 2'd0, 1'b1}); end
    for (int s = 0; s < 4; s++) begin
      eg.cnt_sel = 2'(s); #1;
      total++;
      if (eg.cnt_out !== 8'd0) begin bad++; $display("FAIL reset_cnt sel=%0d got=%0d want=0", s, eg.cnt_out); end
    end
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    for (int i = 0; i < 4; i++) begin push_word(0); push_word(1); end
    eg.active = 1'b1; refresh_empty();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); model_eval(); total++;
      if (pack_got() !== pack_want()) begin bad++; $display("FAIL rstmid_run t=%0t got=%h want=%h", $time, pack_got(), pack_want()); end
      if (g_sel >= 0) seen = 1'b1;
      model_commit();
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rstmid_nopop got=0 want=1"); end
    reset = 1'b1; #2;
    total++;
    if ({eg.pop, eg.valid_out, eg.data_out, eg.class_out, eg.idle_out, eg.cnt_out} !== {4'b0, 1'b0, 12'h0, 2'd0, 1'b1, 8'd0})
      begin bad++; $display("FAIL rstmid_outputs got=%h want=%h", {eg.pop, eg.valid_out, eg.data_out, eg.class_out, eg.idle_out, eg.cnt_out}, {4'b0, 1'b0, 12'h0, 2'd0, 1'b1, 8'd0}); end
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); model_eval(); total++;
      if (pack_got() !== pack_want()) begin bad++; $display("FAIL rstmid_after t=%0t got=%h want=%h", $time, pack_got(), pack_want()); end
      if (i == 0) begin
        total++;
        if (eg.valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_stale got=%b want=0", eg.valid_out); end
      end
      model_commit();
    end
  endtask

  task automatic test_wrr();
    int nv;
    int cc [4];
    do_reset();
    eg.weight[0] = 4'd2; eg.weight[1] = 4'd1; eg.weight[2] = 4'd1; eg.weight[3] = 4'd1;
    for (int i = 0; i < 8; i++) for (int c = 0; c < 4; c++) push_word(c);
    eg.active = 1'b1; refresh_empty();
    nv = 0;
    for (int c = 0; c < 4; c++) cc[c] = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); model_eval(); total++;
      if (pack_got() !== pack_want()) begin bad++; $display("FAIL wrr t=%0t got=%h want=%h", $time, pack_got(), pack_want()); end
      if (eg.valid_out === 1'b1 && nv < 10) begin cc[eg.class_out]++; nv++; end
      model_commit();
    end
    total++;
    if (cc[0] != 4 || cc[1] != 2 || cc[2] != 2 || cc[3] != 2)
      begin bad++; $display("FAIL wrr_share got=%0d,%0d,%0d,%0d want=4,2,2,2", cc[0], cc[1], cc[2], cc[3]); end
  endtask

  task automatic test_single();
    int pulses;
    logic [3:0] prev;
    do_reset();
    eg.weight[2] = 4'($urandom_range(0, 15));
    eg.cnt_sel = 2'd2;
    for (int i = 0; i < 3; i++) push_word(2);
    eg.active = 1'b1; refresh_empty();
    pulses = 0; prev = 4'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); model_eval(); total++;
      if (pack_got() !== pack_want()) begin bad++; $display("FAIL single t=%0t got=%h want=%h", $time, pack_got(), pack_want()); end
      total++;
      if ((eg.pop & prev) !== 4'b0) begin bad++; $display("FAIL single_b2b got=%b want=0000", eg.pop & prev); end
      prev = eg.pop;
      if (eg.valid_out === 1'b1 && eg.class_out === 2'd2) pulses++;
      model_commit();
    end
    @(negedge clk);
    total++;
    if (pulses != 3) begin bad++; $display("FAIL single_pulses got=%0d want=3", pulses); end
    total++;
    if (eg.cnt_out !== 8'd3) begin bad++; $display("FAIL single_cnt got=%0d want=3", eg.cnt_out); end
  endtask

  task automatic test_backpressure();
    bit fired;
    int stall;
    do_reset();
    for (int i = 0; i < 4; i++) begin push_word(0); push_word(1); end
    eg.active = 1'b1; refresh_empty();
    fired = 1'b0; stall = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); model_eval(); total++;
      if (pack_got() !== pack_want()) begin bad++; $display("FAIL bp t=%0t got=%h want=%h", $time, pack_got(), pack_want()); end
      if (stall == 3) begin
        total++;
        if (eg.valid_out !== 1'b1) begin bad++; $display("FAIL bp_present got=%b want=1", eg.valid_out); end
      end
      if (stall > 0) begin
        total++;
        if (eg.pop !== 4'b0) begin bad++; $display("FAIL bp_hold got=%b want=0000", eg.pop); end
      end
      model_commit();
      if (!fired && g_sel >= 0) begin fired = 1'b1; stall = 3; eg.out_almost_full = 1'b1; end
      else if (stall > 0) begin stall--; if (stall == 0) eg.out_almost_full = 1'b0; end
    end
    total++;
    if (!fired) begin bad++; $display("FAIL bp_nopop got=0 want=1"); end
  endtask

  task automatic test_drain();
    int ph;
    do_reset();
    push_word(1); push_word(1);
    eg.active = 1'b1; refresh_empty();
    ph = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); model_eval(); total++;
      if (pack_got() !== pack_want()) begin bad++; $display("FAIL drain t=%0t got=%h want=%h", $time, pack_got(), pack_want()); end
      if (ph == 1) begin
        total++;
        if ({eg.valid_out, eg.class_out, eg.idle_out} !== {1'b1, 2'd1, 1'b0})
          begin bad++; $display("FAIL drain_word got=%b want=1010", {eg.valid_out, eg.class_out, eg.idle_out}); end
      end
      if (ph == 2) begin
        total++;
        if ({eg.idle_out, eg.pop} !== 5'b0) begin bad++; $display("FAIL drain_state got=%b want=00000", {eg.idle_out, eg.pop}); end
      end
      if (ph == 3) begin
        total++;
        if ({eg.idle_out, eg.pop} !== 5'b10000) begin bad++; $display("FAIL drain_idle got=%b want=10000", {eg.idle_out, eg.pop}); end
      end
      model_commit();
      if (ph == 0 && g_sel == 1) begin ph = 1; eg.active = 1'b0; end
      else if (ph > 0 && ph < 4) ph++;
      if (ph == 4) begin eg.active = 1'b1; ph = 5; end
    end
    total++;
    if (ph != 5) begin bad++; $display("FAIL drain_seq got=%0d want=5", ph); end
  endtask

  task automatic test_wrap();
    do_reset();
    eg.cnt_sel = 2'd3;
    eg.weight[3] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 257; i++) push_word(3);
    eg.active = 1'b1; refresh_empty();
    for (int i = 0; i < 560; i++) begin
      @(negedge clk); model_eval(); total++;
      if (pack_got() !== pack_want()) begin bad++; $display("FAIL wrap t=%0t got=%h want=%h", $time, pack_got(), pack_want()); end
      model_commit();
    end
    @(negedge clk);
    total++;
    if (eg.cnt_out !== 8'd1) begin bad++; $display("FAIL wrap_cnt got=%0d want=1", eg.cnt_out); end
  endtask

  task automatic test_random();
    logic [3:0] prev;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 4; c++) begin
        eg.weight[c] = 4'($urandom_range(0, 15));
        for (int n = $urandom_range(0, 8); n > 0; n--) push_word(c);
      end
      eg.cnt_sel = 2'($urandom_range(0, 3));
      eg.active = 1'b1; refresh_empty();
      prev = 4'b0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk); model_eval(); total++;
        if (pack_got() !== pack_want()) begin bad++; $display("FAIL rand r=%0d t=%0t got=%h want=%h", r, $time, pack_got(), pack_want()); end
        total++;
        if (!$onehot0(eg.pop) || (eg.pop & prev) !== 4'b0)
          begin bad++; $display("FAIL rand_pop got=%b prev=%b want=onehot0,disjoint", eg.pop, prev); end
        prev = eg.pop;
        model_commit();
        eg.active = ($urandom_range(0, 9) != 0);
        eg.out_almost_full = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) push_word($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) eg.cnt_sel = 2'($urandom_range(0, 3));
        refresh_empty();
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_wrr();
    test_single();
    test_backpressure();
    test_drain();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qos_egress_arb.md
QOS_EGRESS_ARB -- requirements
Module: qos_egress_arb

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 active  input  1  enable from the QoS FSM; 1 = egress may pop.
REQ-004 empty  input  4  empty flags of the four per-class output FIFOs, bit i = class i.
REQ-005 fifo_data0..fifo_data3  input  12 each  FIFO read data; valid the cycle after the matching pop.
REQ-006 weight0..weight3  input  4 each  WRR weight per class; 0 is treated as 1.
REQ-007 out_almost_full  input  1  downstream backpressure; 1 = no new pop may be issued.
REQ-008 cnt_sel  input  2  selects which per-class word counter drives cnt_out.
REQ-009 pop  output  4  one-hot read strobe to the class FIFOs.
REQ-010 data_out  output  12  merged egress word.
REQ-011 valid_out  output  1  data_out/class_out qualify this cycle.
REQ-012 class_out  output  2  class index of data_out.
REQ-013 cnt_out  output  8  transferred-word count of class cnt_sel.
REQ-014 idle_out  output  1  1 when FSM is in IDLE.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN; encoding 2 bits.
REQ-016 IDLE->RUN when active=1 and empty!=4'b1111; RUN->DRAIN when active falls while a popped word is outstanding; RUN->IDLE when active=0 with nothing outstanding, or when all empty with nothing outstanding; DRAIN->IDLE after the outstanding word is presented.
REQ-017 In RUN, at most one pop bit is asserted per cycle; none when out_almost_full=1, granted class empty=1, or state!=RUN.
REQ-018 The same class is never popped on two consecutive cycles (empty is registered; guards single-entry underflow).
REQ-019 Latency: pop[i] at cycle N -> valid_out=1, data_out=fifo_data_i, class_out=i at cycle N+1 (registered).
REQ-020 A popped word is always presented at N+1 regardless of out_almost_full, active, or state change.
REQ-021 WRR: per-class 4-bit credit; each grant decrements the granted class credit by 1.
REQ-022 Grant pointer stays on current class while credit>0 and not empty, else advances round-robin (0->1->2->3->0) to the next non-empty class with credit>0.
REQ-023 When every non-empty class has credit 0, all credits reload from weights (0 -> 1) in the same cycle and grant proceeds from the pointer.
REQ-024 Where REQ-018 blocks the current class, the next eligible class is granted; if none, no pop that cycle (credit unchanged).
REQ-025 Per-class 8-bit word counter increments on each valid_out of that class; wraps 255->0.
REQ-026 cnt_out combinational mux of counters by cnt_sel.
REQ-027 valid_out=0 whenever no pop occurred in the previous cycle; data_out holds last value.

Reset
REQ-028 reset=1 forces asynchronously: state=IDLE, pop=0, valid_out=0, data_out=0, class_out=0, counters=0, credits=0 (reload on first arbitration), pointer=class 0, idle_out=1.
REQ-029 Reset asserted mid-transfer discards any outstanding word; no valid_out follows deassertion.

Structure
REQ-030 Shared package holds: state encodings, data width 12, class count 4, counter width 8, credit width 4.
REQ-031 One sub-module: qos_wrr_grant (credit registers, pointer, eligibility, one-hot grant); FSM, output register, counters in top.

Verification
REQ-032 Reset: assert reset mid-RUN with a pop outstanding -> all outputs 0, idle_out=1, no valid_out after release.
REQ-033 Weights 2,1,1,1, all FIFOs holding 8 words, active=1 -> grant order 0,x,0,... respecting no-back-to-back; over 10 words class 0 gets 4, others 2 each.
REQ-034 Only class 2 non-empty with 3 words -> pops at alternate cycles, valid_out pulses 3 times, class_out=2, cnt_sel=2 gives cnt_out=3.
REQ-035 out_almost_full=1 one cycle after a pop -> that word still presented next cycle, no further pop until deasserted.
REQ-036 active drops the cycle after pop[1] -> state DRAIN, word presented with class_out=1, then IDLE, pop=0.
REQ-037 Class 3 receives 257 words -> cnt_out (cnt_sel=3) = 1 (wrap).
